// File: rtl/cache_pkg.sv
// Shared cache definitions: request-FSM state encodings and the SDREQ issue stage's
// state and owner enums.
package cache_pkg;

    localparam logic [2:0] CDREQ_INIT_SDREQ = 3'd2;
    localparam logic [2:0] SUREQ_INIT_SDREQ = 3'd3;

    typedef enum logic [1:0] {
        SDI_IDLE     = 2'd0,
        SDI_ISSUE    = 2'd1,
        SDI_WAIT_RSP = 2'd2
    } sdi_state_e;

    typedef enum logic {
        OWN_CD = 1'b0,
        OWN_SU = 1'b1
    } sdi_owner_e;

endpackage

// File: rtl/sdreq_issue_ctrl_if.sv
// SDREQ request channel plus SURSP response handshake.
// The master modport belongs to the issue stage; the slave modport belongs to the downstream side.
interface sdreq_issue_ctrl_if #(
    parameter int SADDR_WIDTH = 32,
    parameter int BLK_WIDTH   = 512,
    parameter int OP_WIDTH    = 2
) ();
    logic                   sdreq_valid;
    logic                   sdreq_ready;
    logic [OP_WIDTH-1:0]    sdreq_op;
    logic [SADDR_WIDTH-1:0] sdreq_addr;
    logic [BLK_WIDTH-1:0]   sdreq_data;
    logic                   sursp_valid;
    logic                   sursp_ready;

    modport master (
        output sdreq_valid, sdreq_op, sdreq_addr, sdreq_data, sursp_ready,
        input  sdreq_ready, sursp_valid
    );

    modport slave (
        input  sdreq_valid, sdreq_op, sdreq_addr, sdreq_data, sursp_ready,
        output sdreq_ready, sursp_valid
    );
endinterface

// File: rtl/sdreq_timeout_wdt.sv
// Watchdog for the WAIT_RSP phase: counts cycles spent waiting and raises a sticky flag
// once TIMEOUT_CYCLES have elapsed. The flag never aborts the transaction.
module sdreq_timeout_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout_reg;

    // The counter saturates at LIMIT so a very late response cannot wrap it.
    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (active && (cnt_reg != LIMIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (active && (cnt_next == LIMIT)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
endmodule

// File: rtl/sdreq_issue_ctrl.sv
// SDREQ issue stage: arbitrates CDREQ/SUREQ, issues one SDREQ and waits for its SURSP.
// Define SDREQ_TIMEOUT_EN to add the WAIT_RSP watchdog and the sdreq_timeout port.
module sdreq_issue_ctrl
    import cache_pkg::*;
#(
    parameter int SADDR_WIDTH    = 32,
    parameter int BLK_WIDTH      = 512,
    parameter int OP_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             cdreq_req_curSt,
    input  logic [2:0]             sureq_req_curSt,
    input  logic [OP_WIDTH-1:0]    cdreq_sdreq_op,
    input  logic [SADDR_WIDTH-1:0] cdreq_sdreq_addr,
    input  logic [BLK_WIDTH-1:0]   cdreq_sdreq_data,
    input  logic [OP_WIDTH-1:0]    sureq_sdreq_op,
    input  logic [SADDR_WIDTH-1:0] sureq_sdreq_addr,
    input  logic [BLK_WIDTH-1:0]   sureq_sdreq_data,
    sdreq_issue_ctrl_if.master     sd_if,
    output logic                   cdreq_sdreq_hs_compack,
    output logic                   sureq_sdreq_hs_compack,
    output logic                   cdreq_sursp_hs_en,
    output logic                   sureq_sursp_hs_en,
    output logic                   busy
`ifdef SDREQ_TIMEOUT_EN
    ,
    output logic                   sdreq_timeout
`endif
);

    sdi_state_e             state_reg, state_next;
    sdi_owner_e             owner_reg;
    logic [OP_WIDTH-1:0]    op_reg;
    logic [SADDR_WIDTH-1:0] addr_reg;
    logic [BLK_WIDTH-1:0]   data_reg;

    logic su_req, cd_req;
    logic launch, issue_hs, rsp_hs;

    // Index 0 is the CDREQ source, index 1 the SUREQ source.
    logic [1:0] own_onehot;
    logic [1:0] compack_reg;
    logic [1:0] rsp_en_reg;

    assign su_req     = (sureq_req_curSt == SUREQ_INIT_SDREQ);
    assign cd_req     = (cdreq_req_curSt == CDREQ_INIT_SDREQ);
    assign own_onehot = {owner_reg == OWN_SU, owner_reg == OWN_CD};

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        issue_hs   = 1'b0;
        rsp_hs     = 1'b0;
        unique case (state_reg)
            SDI_IDLE: begin
                if (su_req || cd_req) begin
                    launch     = 1'b1;
                    state_next = SDI_ISSUE;
                end
            end
            SDI_ISSUE: begin
                if (sd_if.sdreq_ready) begin
                    issue_hs   = 1'b1;
                    state_next = SDI_WAIT_RSP;
                end
            end
            SDI_WAIT_RSP: begin
                if (sd_if.sursp_valid) begin
                    rsp_hs     = 1'b1;
                    state_next = SDI_IDLE;
                end
            end
            default: state_next = SDI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SDI_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SUREQ wins ties so a snoop writeback is never stuck behind a CPU miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= OWN_CD;
            op_reg    <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (launch) begin
            owner_reg <= su_req ? OWN_SU : OWN_CD;
            op_reg    <= su_req ? sureq_sdreq_op   : cdreq_sdreq_op;
            addr_reg  <= su_req ? sureq_sdreq_addr : cdreq_sdreq_addr;
            data_reg  <= su_req ? sureq_sdreq_data : cdreq_sdreq_data;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                compack_reg[gi] <= 1'b0;
                rsp_en_reg[gi]  <= 1'b0;
            end else begin
                compack_reg[gi] <= issue_hs && own_onehot[gi];
                rsp_en_reg[gi]  <= rsp_hs && own_onehot[gi];
            end
        end
    end

    assign sd_if.sdreq_valid = (state_reg == SDI_ISSUE);
    assign sd_if.sursp_ready = (state_reg == SDI_WAIT_RSP);
    assign sd_if.sdreq_op    = op_reg;
    assign sd_if.sdreq_addr  = addr_reg;
    assign sd_if.sdreq_data  = data_reg;

    assign cdreq_sdreq_hs_compack = compack_reg[0];
    assign sureq_sdreq_hs_compack = compack_reg[1];
    assign cdreq_sursp_hs_en      = rsp_en_reg[0];
    assign sureq_sursp_hs_en      = rsp_en_reg[1];
    assign busy                   = (state_reg != SDI_IDLE);

`ifdef SDREQ_TIMEOUT_EN
    sdreq_timeout_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clear  (issue_hs),
        .active (state_reg == SDI_WAIT_RSP),
        .timeout(sdreq_timeout)
    );
`endif

endmodule

// File: tb/tb_sdreq_issue_ctrl.sv
// Randomized and directed bench for sdreq_issue_ctrl against a transaction-level reference model.
module tb_sdreq_issue_ctrl;
    import cache_pkg::*;

    localparam int SAW = 32;
    localparam int BLK = 512;
    localparam int OPW = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]     cd_st, su_st;
    logic [OPW-1:0] cd_op, su_op;
    logic [SAW-1:0] cd_addr, su_addr;
    logic [BLK-1:0] cd_data, su_data;
    logic           cd_cpk, su_cpk, cd_hs, su_hs, busy;
`ifdef SDREQ_TIMEOUT_EN
    logic           sdreq_timeout;
`endif

    sdreq_issue_ctrl_if #(.SADDR_WIDTH(SAW), .BLK_WIDTH(BLK), .OP_WIDTH(OPW)) sd_if ();

    sdreq_issue_ctrl #(
        .SADDR_WIDTH(SAW), .BLK_WIDTH(BLK), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cdreq_req_curSt       (cd_st),
        .sureq_req_curSt       (su_st),
        .cdreq_sdreq_op        (cd_op),
        .cdreq_sdreq_addr      (cd_addr),
        .cdreq_sdreq_data      (cd_data),
        .sureq_sdreq_op        (su_op),
        .sureq_sdreq_addr      (su_addr),
        .sureq_sdreq_data      (su_data),
        .sd_if                 (sd_if.master),
        .cdreq_sdreq_hs_compack(cd_cpk),
        .sureq_sdreq_hs_compack(su_cpk),
        .cdreq_sursp_hs_en     (cd_hs),
        .sureq_sursp_hs_en     (su_hs),
        .busy                  (busy)
`ifdef SDREQ_TIMEOUT_EN
        ,
        .sdreq_timeout         (sdreq_timeout)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_txn    = 0;

    // Reference model: one outstanding transaction, described by whether it exists,
    // whether the request has been accepted, and who owns it.
    bit             m_active, m_sent, m_own_su;
    logic [OPW-1:0] m_op;
    logic [SAW-1:0] m_addr;
    logic [BLK-1:0] m_data;
    bit             m_cd_cpk, m_su_cpk, m_cd_hs, m_su_hs, m_tmo;
    int             m_wait;

    task automatic check_val(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_sent = 0; m_own_su = 0;
        m_op = '0; m_addr = '0; m_data = '0;
        m_cd_cpk = 0; m_su_cpk = 0; m_cd_hs = 0; m_su_hs = 0;
        m_tmo = 0; m_wait = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit c_cpk = 0, s_cpk = 0, c_hs = 0, s_hs = 0;
        if (m_active && m_sent) begin
            m_wait++;
            if (m_wait >= TMO) m_tmo = 1;
        end
        if (!m_active) begin
            if (su_st == SUREQ_INIT_SDREQ) begin
                m_active = 1; m_sent = 0; m_own_su = 1;
                m_op = su_op; m_addr = su_addr; m_data = su_data;
            end else if (cd_st == CDREQ_INIT_SDREQ) begin
                m_active = 1; m_sent = 0; m_own_su = 0;
                m_op = cd_op; m_addr = cd_addr; m_data = cd_data;
            end
        end else if (!m_sent) begin
            if (sd_if.sdreq_ready) begin
                m_sent = 1; m_wait = 0;
                if (m_own_su) s_cpk = 1; else c_cpk = 1;
            end
        end else if (sd_if.sursp_valid) begin
            m_active = 0;
            if (m_own_su) s_hs = 1; else c_hs = 1;
            n_txn++;
            $display("txn %0d done: owner=%s op=%0d addr=%h", n_txn, m_own_su ? "SU" : "CD", m_op, m_addr);
        end
        m_cd_cpk = c_cpk; m_su_cpk = s_cpk; m_cd_hs = c_hs; m_su_hs = s_hs;
    endtask

    task automatic check_all();
        check_val("sdreq_valid", BLK'(sd_if.sdreq_valid), BLK'(m_active && !m_sent));
        check_val("sursp_ready", BLK'(sd_if.sursp_ready), BLK'(m_active && m_sent));
        check_val("busy",        BLK'(busy),              BLK'(m_active));
        check_val("sdreq_op",    BLK'(sd_if.sdreq_op),    BLK'(m_op));
        check_val("sdreq_addr",  BLK'(sd_if.sdreq_addr),  BLK'(m_addr));
        check_val("sdreq_data",  sd_if.sdreq_data,        m_data);
        check_val("cd_compack",  BLK'(cd_cpk),            BLK'(m_cd_cpk));
        check_val("su_compack",  BLK'(su_cpk),            BLK'(m_su_cpk));
        check_val("cd_hs_en",    BLK'(cd_hs),             BLK'(m_cd_hs));
        check_val("su_hs_en",    BLK'(su_hs),             BLK'(m_su_hs));
`ifdef SDREQ_TIMEOUT_EN
        check_val("sdreq_timeout", BLK'(sdreq_timeout),   BLK'(m_tmo));
`endif
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    function automatic logic [BLK-1:0] rand_blk();
        logic [BLK-1:0] v;
        for (int i = 0; i < BLK / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_payload();
        cd_op = OPW'($urandom); cd_addr = $urandom; cd_data = rand_blk();
        su_op = OPW'($urandom); su_addr = $urandom; su_data = rand_blk();
    endtask

    initial begin
        cd_st = 3'd0; su_st = 3'd0;
        cd_op = '0; su_op = '0; cd_addr = '0; su_addr = '0; cd_data = '0; su_data = '0;
        sd_if.sdreq_ready = 1'b0;
        sd_if.sursp_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // CDREQ alone, ready tied high, response three cycles after acceptance
        rand_payload();
        cd_addr = 32'h100; cd_st = CDREQ_INIT_SDREQ; sd_if.sdreq_ready = 1'b1;
        tick(); tick();
        cd_st = 3'd0;
        repeat (3) tick();
        sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick(); tick();

        // Both sources requesting: SU first, CD once SU has left INIT_SDREQ
        rand_payload();
        su_addr = 32'h200; cd_addr = 32'h300;
        su_st = SUREQ_INIT_SDREQ; cd_st = CDREQ_INIT_SDREQ;
        tick(); tick();
        su_st = 3'd0;
        tick();
        sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick(); tick();
        cd_st = 3'd0; tick();
        sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick();

        // Backpressure with the source payload changing underneath
        rand_payload();
        sd_if.sdreq_ready = 1'b0; cd_st = CDREQ_INIT_SDREQ;
        tick();
        cd_st = 3'd0;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            tick();
        end
        sd_if.sdreq_ready = 1'b1; tick();
        sd_if.sdreq_ready = 1'b0; sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick();

        // Stray responses in IDLE and ISSUE
        sd_if.sursp_valid = 1'b1; tick();
        cd_st = CDREQ_INIT_SDREQ; tick();
        cd_st = 3'd0; tick(); tick();
        sd_if.sursp_valid = 1'b0; sd_if.sdreq_ready = 1'b1; tick();
        sd_if.sdreq_ready = 1'b0; sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick();

        // Reset while waiting for a response
        rand_payload();
        cd_st = CDREQ_INIT_SDREQ; sd_if.sdreq_ready = 1'b1;
        tick(); tick();
        cd_st = 3'd0; sd_if.sdreq_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        cyc++;
        check_all();
        rst = 1'b0;
        sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick();

`ifdef SDREQ_TIMEOUT_EN
        // No response for a long time, then a late one
        rand_payload();
        cd_st = CDREQ_INIT_SDREQ; sd_if.sdreq_ready = 1'b1;
        tick(); tick();
        cd_st = 3'd0; sd_if.sdreq_ready = 1'b0;
        repeat (12) tick();
        sd_if.sursp_valid = 1'b1; tick();
        sd_if.sursp_valid = 1'b0; tick(); tick();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_payload();
            su_st = ($urandom_range(0, 3) == 0) ? SUREQ_INIT_SDREQ : 3'($urandom_range(0, 7));
            cd_st = ($urandom_range(0, 2) == 0) ? CDREQ_INIT_SDREQ : 3'($urandom_range(0, 7));
            sd_if.sdreq_ready = ($urandom_range(0, 1) == 1);
            sd_if.sursp_valid = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdreq_issue_ctrl.md
# sdreq_issue_ctrl

Downstream-request issue stage between the cache's two request FSMs (CDREQ and SUREQ) and the shared SDREQ/SURSP channel pair. It arbitrates between the two FSMs when they sit in their INIT_SDREQ state and drives one SDREQ transaction at a time with a valid/ready handshake. It then waits for the matching SURSP and returns per-source handshake-complete pulses to the owning FSM. This block produces the `sdreq_hs_compack` and `sursp_hs_en` inputs of the state controller.

## Interface
Parameters:
- SADDR_WIDTH, 32, downstream address width
- BLK_WIDTH, 512, cache block data width
- OP_WIDTH, 2, SDREQ opcode width
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_RSP (used only with SDREQ_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- cdreq_req_curSt  input  3  CDREQ FSM state
- sureq_req_curSt  input  3  SUREQ FSM state
- cdreq_sdreq_op / _addr / _data  input  OP_WIDTH / SADDR_WIDTH / BLK_WIDTH  CDREQ-side payload
- sureq_sdreq_op / _addr / _data  input  OP_WIDTH / SADDR_WIDTH / BLK_WIDTH  SUREQ-side payload
- sdreq_valid  output  1  request valid
- sdreq_ready  input  1  downstream accepts
- sdreq_op / sdreq_addr / sdreq_data  output  OP_WIDTH / SADDR_WIDTH / BLK_WIDTH  latched payload
- sursp_valid  input  1  response valid
- sursp_ready  output  1  response accepted
- cdreq_sdreq_hs_compack, sureq_sdreq_hs_compack  output  1  one-cycle issue-complete pulse per source
- cdreq_sursp_hs_en, sureq_sursp_hs_en  output  1  one-cycle response-received pulse per source
- busy  output  1  state != IDLE
- sdreq_timeout  output  1  sticky watchdog flag (present only with SDREQ_TIMEOUT_EN)

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP. Only one transaction is outstanding at a time.
- IDLE:
  - If sureq_req_curSt == SUREQ_INIT_SDREQ, owner = SU. SUREQ has fixed priority because a snoop writeback must never be blocked behind a CPU miss.
  - Else if cdreq_req_curSt == CDREQ_INIT_SDREQ, owner = CD.
  - On either: latch the owner's op/addr/data into the output registers, set sdreq_valid = 1, go to ISSUE.
- ISSUE:
  - Hold sdreq_valid and the payload stable until sdreq_valid && sdreq_ready.
  - On that handshake: clear sdreq_valid, pulse the owner's sdreq_hs_compack on the next cycle, go to WAIT_RSP.
  - Changes on the state inputs during ISSUE are ignored.
- WAIT_RSP:
  - sursp_ready = 1, decoded from state.
  - When sursp_valid: pulse the owner's sursp_hs_en on the next cycle, go to IDLE.
- sursp_valid outside WAIT_RSP: ready stays 0, the response is not consumed, no pulse is generated.
- The non-owner's pulses stay 0 at all times.

## Timing
- Reset values: sdreq_valid = 0, sursp_ready = 0, all pulses = 0, busy = 0, payload = 0, owner = CD, state = IDLE, sdreq_timeout = 0.
- Reset asserted mid-transaction: the transaction is dropped and the block returns to IDLE immediately.
- Arbitration latency: INIT_SDREQ seen at cycle N gives sdreq_valid = 1 at N+1.
- Handshake at cycle M gives compack = 1 at M+1 only. sdreq_valid = 0 from M+1.
- sursp handshake at cycle R gives sursp_hs_en = 1 at R+1 and state = IDLE at R+1.
  - A new issue cannot start before R+2, after the FSM has left WAIT_SURSP.
- Both sources in INIT_SDREQ in the same cycle: SU is issued. CD is issued on the first IDLE cycle in which SU is no longer in INIT_SDREQ.
- The compack pulse is registered, so the owning FSM leaves INIT_SDREQ before this block returns to IDLE. No double issue is possible.

## Configuration
- SDREQ_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - When it reaches TIMEOUT_CYCLES, sdreq_timeout is set. It is sticky until reset.
  - The FSM keeps waiting; the flag does not abort the transaction.
- SDREQ_TIMEOUT_EN undefined: no counter and no sdreq_timeout port.

## Structure
- The following belong in shared cache_pkg:
  - state-encoding constants CDREQ_INIT_SDREQ and SUREQ_INIT_SDREQ
  - the block's FSM enum (SDI_IDLE, SDI_ISSUE, SDI_WAIT_RSP)
  - the owner enum (OWN_CD, OWN_SU)
- One sub-module, sdreq_timeout_wdt, holds the watchdog counter. It is instantiated only under SDREQ_TIMEOUT_EN.

## Test plan
- CDREQ only: cdreq state = INIT_SDREQ, addr = 0x100, ready tied 1 -> valid at N+1, cdreq_sdreq_hs_compack at N+2; sursp_valid 3 cycles later -> single cdreq_sursp_hs_en pulse, busy = 0.
- Simultaneous requests: both states = INIT_SDREQ, su addr = 0x200, cd addr = 0x300 -> 0x200 issued first; 0x300 issued only after SU leaves INIT_SDREQ.
- Backpressure: sdreq_ready low for 5 cycles, source payload changed meanwhile -> sdreq_addr/op/data stable, valid held, compack only after ready rises.
- Stray response: sursp_valid pulsed in IDLE and in ISSUE -> sursp_ready = 0, no hs_en pulses.
- Reset mid-WAIT_RSP: rst pulsed -> all outputs at reset values in the same cycle, no pulse after release.
- With SDREQ_TIMEOUT_EN and TIMEOUT_CYCLES = 8: no sursp -> sdreq_timeout = 1 after 8 WAIT_RSP cycles; a late sursp still completes normally and the flag stays 1.
